// File: rtl/seq_det_param.sv
// ---------------------------------------------------------------------------
// seq_det_param
//
// Serial pattern detector with a runtime-loadable N-bit pattern, selectable
// overlapping / non-overlapping detection and a saturating match counter.
//
// The pattern is read MSB first: pattern[N-1] is the first bit expected on
// the serial input. A bit is taken in only on a "sample cycle"
// (en=1 and load=0). The detector emits a one-cycle registered pulse on
// `out` for the edge on which the final pattern bit was sampled.
//
// Ports
//   clk      : in  single clock, rising-edge active
//   rst_n    : in  asynchronous active-low reset
//   en       : in  qualifies `in`; a bit is sampled only when en=1
//   in       : in  serial data bit
//   pattern  : in  [N-1:0] new pattern, captured when load=1
//   load     : in  capture `pattern`, flush history, discard `in`
//   overlap  : in  1 = overlapping detection, 0 = non-overlapping
//   clr_cnt  : in  synchronous clear of the match counter
//   out      : out registered one-cycle match pulse
//   count    : out [CNT_W-1:0] saturating match count
// ---------------------------------------------------------------------------
module seq_det_param #(
    parameter int             N       = 4,
    parameter int             CNT_W   = 8,
    parameter logic [N-1:0]   PAT_RST = N'(4'b0110)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in,
    input  logic [N-1:0]     pattern,
    input  logic             load,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] count
);

    // fill counts valid history bits, 0..N-1
    localparam int                FILL_W    = $clog2(N);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [N-1:0]       pat_q,   pat_d;
    logic [N-2:0]       hist_q,  hist_d;
    logic [FILL_W-1:0]  fill_q,  fill_d;
    logic               out_q,   out_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               sampleCycle;
    logic               match;
    logic [N-1:0]       window;

    // A load cycle always wins over en so the bit presented alongside a new
    // pattern never leaks into the fresh window.
    assign sampleCycle = en && !load;

    // Current candidate window: the N-1 held bits followed by the incoming
    // bit. Its low N-1 bits are also the next history, which avoids a
    // degenerate slice when N=2.
    assign window = {hist_q, in};
    assign match  = sampleCycle && (fill_q == FILL_FULL) && (window == pat_q);

    // Next-state for pattern, history and fill. In overlapping mode fill
    // simply stays saturated after a match so the tail of one match can seed
    // the next; in non-overlapping mode fill restarts so N fresh bits are
    // needed and the stale history contents no longer matter.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (load) begin
            pat_d  = pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (sampleCycle) begin
            hist_d = window[N-2:0];
            if (match && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // Match counter. A clear that coincides with a match leaves the count
    // at one so that match is still accounted for; otherwise the counter
    // saturates rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (clr_cnt) begin
            count_d = match ? CNT_W'(1) : '0;
        end else if (match && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign out_d = match;

    // All state lives here; reset restores the power-on pattern and drops
    // any partial progress without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= PAT_RST;
            hist_q  <= '0;
            fill_q  <= '0;
            out_q   <= 1'b0;
            count_q <= '0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
            count_q <= count_d;
        end
    end

    assign out   = out_q;
    assign count = count_q;

endmodule

// File: tb/tb_seq_det_param.sv
// ---------------------------------------------------------------------------
// tb_seq_det_param
//
// Drives two detector instances from the same stimulus: one with the default
// 8-bit counter and one with a 2-bit counter so saturation is reachable.
// A bit-queue model predicts out/count every cycle; directed scenarios add
// hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_seq_det_param;

    localparam int N = 4;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         en      = 1'b0;
    logic         in      = 1'b0;
    logic         load    = 1'b0;
    logic         overlap = 1'b1;
    logic         clrCnt  = 1'b0;
    logic [N-1:0] pattern = '0;

    logic         outA;
    logic         outB;
    logic [7:0]   countA;
    logic [1:0]   countB;

    int checks = 0;
    int errors = 0;

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    seq_det_param #(.N(4), .CNT_W(8), .PAT_RST(4'b0110)) dutA (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in), .pattern(pattern),
        .load(load), .overlap(overlap), .clr_cnt(clrCnt),
        .out(outA), .count(countA)
    );

    seq_det_param #(.N(4), .CNT_W(2), .PAT_RST(4'b0110)) dutB (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in), .pattern(pattern),
        .load(load), .overlap(overlap), .clr_cnt(clrCnt),
        .out(outB), .count(countB)
    );

    // Reference model: keeps the sampled bits of the current window in a
    // queue and declares a match when the last N of them spell the pattern.
    int   modelPat  = 6;
    int   bitQ[$];
    logic modelOut  = 1'b0;
    int   modelCntA = 0;
    int   modelCntB = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int word;
        bit hit;
        if (!rst_n) begin
            modelPat  = 6;
            bitQ.delete();
            modelOut  = 1'b0;
            modelCntA = 0;
            modelCntB = 0;
        end else begin
            hit = 1'b0;
            if (load) begin
                modelPat = int'(pattern);
                bitQ.delete();
            end else if (en) begin
                bitQ.push_back(int'(in));
                if (bitQ.size() == N) begin
                    word = 0;
                    foreach (bitQ[k]) word = word * 2 + bitQ[k];
                    hit = (word == modelPat);
                end
                if (hit && !overlap) begin
                    bitQ.delete();
                end else if (bitQ.size() == N) begin
                    void'(bitQ.pop_front());
                end
            end
            modelOut = hit;
            if (clrCnt) begin
                modelCntA = hit ? 1 : 0;
                modelCntB = hit ? 1 : 0;
            end else if (hit) begin
                modelCntA = (modelCntA < 255) ? modelCntA + 1 : 255;
                modelCntB = (modelCntB < 3) ? modelCntB + 1 : 3;
            end
        end
    end

    // Every cycle out of reset, compare both instances against the model
    // half a period after the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (outA !== modelOut || outB !== modelOut ||
                countA !== 8'(modelCntA) || countB !== 2'(modelCntB)) begin
                errors++;
                $display("[TB] FAIL model_cmp t=%0t: outA=%0b outB=%0b countA=%0d countB=%0d, expected out=%0b countA=%0d countB=%0d",
                         $time, outA, outB, countA, countB, modelOut, modelCntA, modelCntB);
            end
        end
    end

    // Present one cycle of inputs, let the active edge consume them, and
    // return 2 units after that edge so outputs can be inspected.
    task automatic applyStimulus(input logic e, input logic b, input logic l,
                                 input logic [N-1:0] p, input logic ov,
                                 input logic c);
        en      = e;
        in      = b;
        load    = l;
        pattern = p;
        overlap = ov;
        clrCnt  = c;
        @(posedge clk);
        #2;
    endtask

    // Literal check of both instances
    task automatic checkOutput(input string name, input logic expOut,
                               input int expA, input int expB);
        checks++;
        if (outA !== expOut || outB !== expOut ||
            countA !== 8'(expA) || countB !== 2'(expB)) begin
            errors++;
            $display("[TB] FAIL %s: outA=%0b outB=%0b countA=%0d countB=%0d, expected out=%0b countA=%0d countB=%0d",
                     name, outA, outB, countA, countB, expOut, expA, expB);
        end
    endtask

    bit seqA[7]    = '{0, 1, 1, 0, 1, 1, 0};
    bit expOvl[7]  = '{0, 0, 0, 1, 0, 0, 1};
    int cntOvl[7]  = '{0, 0, 0, 1, 1, 1, 2};
    bit expNovl[7] = '{0, 0, 0, 1, 0, 0, 0};
    int satB[5]    = '{1, 2, 3, 3, 3};

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_state", 1'b0, 0, 0);
        rst_n = 1'b1;

        // Overlapping detection of 0110 in 0110110
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, seqA[i], 1'b0, 4'b0000, 1'b1, 1'b0);
            checkOutput($sformatf("ovl_bit%0d", i + 1), expOvl[i], cntOvl[i], cntOvl[i]);
        end

        // Fresh window, counter cleared, same stream non-overlapping
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b1);
        checkOutput("reload_clr", 1'b0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, seqA[i], 1'b0, 4'b0000, 1'b0, 1'b0);
            checkOutput($sformatf("novl_bit%0d", i + 1), expNovl[i], i >= 3 ? 1 : 0, i >= 3 ? 1 : 0);
        end

        // Enable gap in the middle of a pattern
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, i[0], 1'b0, 4'b0000, 1'b1, 1'b0);
            checkOutput($sformatf("gap%0d", i), 1'b0, 0, 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("gap_bit3", 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("gap_bit4", 1'b1, 1, 1);

        // Load 1111 with en=1 and in=1: that bit must be discarded
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
        checkOutput("load_cycle", 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
            checkOutput($sformatf("ones_bit%0d", i + 1), i >= 3, i >= 3 ? i - 2 : 0, i >= 3 ? i - 2 : 0);
        end

        // Counter saturation on the 2-bit instance
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
            checkOutput($sformatf("sat_match%0d", i + 1), 1'b1, i + 1, satB[i]);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
        checkOutput("clr_on_match", 1'b1, 1, 1);

        // Asynchronous reset while out=1 and count=1
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out", 1'b0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset between bits 3 and 4 of 0110 (pattern back to reset value)
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("pre_mid_reset", 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset", 1'b0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("lone_bit4", 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, seqA[i], 1'b0, 4'b0000, 1'b1, 1'b0);
            checkOutput($sformatf("post_reset_bit%0d", i + 1), i == 3, i == 3 ? 1 : 0, i == 3 ? 1 : 0);
        end

        // Idle cycle: out must fall back to 0
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("idle_after_match", 1'b0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter N, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: match-counter width; legal range 1..16.
REQ-003 Parameter PAT_RST, default 4'b0110 (N bits): pattern value loaded at reset.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port en, input, 1 bit: qualifies `in`; a bit is sampled only when en=1.
REQ-007 Port in, input, 1 bit: serial data bit.
REQ-008 Port pattern, input, N bits: new pattern; pattern[N-1] is the first bit of the sequence.
REQ-009 Port load, input, 1 bit: capture `pattern` into the internal pattern register.
REQ-010 Port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-011 Port clr_cnt, input, 1 bit: synchronous clear of the match counter.
REQ-012 Port out, output, 1 bit: registered one-cycle match pulse.
REQ-013 Port count, output, CNT_W bits: saturating count of matches.

Function
REQ-014 The block SHALL hold the following registered state:
- pat_r (N bits): active pattern.
- hist (N-1 bits): the most recent sampled bits; the newest bit is at hist[0].
- fill (0..N-1): number of valid bits held in hist.
REQ-015 Sample cycle = en=1 and load=0; on a sample cycle, hist <= {hist[N-3:0], in}, and fill increments, saturating at N-1.
REQ-016 match SHALL be 1 iff the cycle is a sample cycle, fill==N-1, and {hist, in}==pat_r.
REQ-017 On each edge, out <= match; out is therefore high for exactly the one cycle after the final pattern bit is sampled (latency 1 edge).
REQ-018 overlap=1: a match does not alter fill, so the trailing bits of a match can begin the next match.
REQ-019 overlap=0: on a match, fill <= 0, so the next match requires N fresh sampled bits (hist contents are don't-care).
REQ-020 overlap SHALL be sampled every cycle; changing it between matches takes effect on the next sample cycle.
REQ-021 Non-sample cycles SHALL leave hist, fill and count unchanged, and SHALL drive out <= 0 on the next edge.
REQ-022 load=1 SHALL set pat_r <= pattern, hist <= 0 and fill <= 0.
REQ-023 When load=1, `in` is discarded and no match is generated, including when en=1 in the same cycle.
REQ-024 On a match, count SHALL increment by 1, saturating at 2^CNT_W-1; it SHALL never wrap.
REQ-025 clr_cnt=1 without a match SHALL set count <= 0.
REQ-026 clr_cnt=1 together with a match SHALL set count <= 1, so that match is not lost.
REQ-027 An all-zeros or all-ones pat_r is legal; with overlap=1, a constant input produces out=1 on every sample cycle after the first N-1.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force:
- pat_r = PAT_RST
- hist = 0, fill = 0
- out = 0, count = 0
REQ-029 Reset asserted mid-sequence SHALL discard all partial progress.
REQ-030 After rst_n deasserts, the first sampled bit counts as bit 1 of a new window.

Verification
REQ-031 Reset pattern 0110, overlap=1, en=1, stream 0,1,1,0,1,1,0 -> out pulses after bit 4 and after bit 7; count=2.
REQ-032 Same stream with overlap=0 -> single pulse after bit 4; count=1.
REQ-033 Stream 0,1,(en=0 for 3 cycles),1,0 -> out=0 throughout the gap; one pulse after the final 0; count=1.
REQ-034 load with pattern=4'b1111 and en=1 in the same cycle, then 1,1,1,1,1 with overlap=1 -> loaded bit ignored; pulses after the 4th and 5th sampled 1; count=2.
REQ-035 CNT_W=2, 5 matches -> count sequence 1,2,3,3,3; clr_cnt asserted on a match cycle -> count=1.
REQ-036 rst_n pulsed low between bits 3 and 4 of 0110 -> out and count immediately 0; bit 4 alone produces no pulse; a full 0110 afterwards pulses once.
